ifft8_stream: RTL and testbench
===============================

// Module: ifft8_stream
// PURPOSE
// - 8-point radix-2 DIT inverse FFT, Q8.8 complex, time-multiplexed: one butterfly per clock.
// - Back end of the spectral path: takes 8 frequency bins from the 8-point forward FFT, returns 8 time samples.
// - Streams bins in and samples out over valid/ready. Internal 8-entry complex buffer, one frame in flight.
// PARAMETERS
// - DATA_W  16       : sample width per real/imag component (signed two's complement)
// - FRAC_W  8        : fractional bits (Q8.8)
// - TW_COEF 16'h00B4 : 1/sqrt(2) in Q8.8 (180/256)
// PORTS
// - clk        in   1       : clock, rising edge
// - rst        in   1       : synchronous reset, active-high
// - in_valid   in   1       : input bin valid
// - in_ready   out  1       : block accepts a bin; high only in LOAD
// - in_real    in   DATA_W  : bin real part, X[0]..X[7] in natural order
// - in_imag    in   DATA_W  : bin imag part
// - out_valid  out  1       : output sample valid
// - out_ready  in   1       : downstream accepts a sample
// - out_real   out  DATA_W  : time sample real part, x[0]..x[7] in natural order
// - out_imag   out  DATA_W  : time sample imag part
// - out_last   out  1       : high with x[7]
// - busy       out  1       : high in CALC or OUT
// BEHAVIOUR
// - Reset values: in_ready=0, out_valid=0, out_last=0, busy=0, out_real=out_imag=0; state->LOAD, counters=0.
//   in_ready goes high on the first cycle after rst deasserts.
// - FSM LOAD -> CALC -> OUT -> LOAD.
// - LOAD: in_ready=1. Each in_valid&in_ready cycle writes bin k to buffer[bitrev3(k)] and increments k.
//   The 8th accept moves to CALC on the next cycle.
// - CALC: 12 cycles: stage s=1..3, butterflies b=0..3, one per cycle.
//   - Each cycle reads two entries (p, q=p+span) and writes both back in the same cycle. span = 1, 2, 4.
//   - Twiddle is conj(W8^k): k=0 for s1; k in {0,2} for s2; k in {0,1,2,3} for s3.
//   - Butterfly: t=B*Wc; A'=A+t; B'=A-t.
//   - Wc^0: t=B.
//   - Wc^2 (+j): t=(-Bi, Br).
//   - Wc^1: t=(c*(Br-Bi), c*(Br+Bi)).
//   - Wc^3: t=(c*(-Br-Bi), c*(Br-Bi)).
//   - c*v uses a sign-magnitude multiply: |v|*TW_COEF (32-bit), keep bits [23:8], re-apply the sign.
//     This truncates toward zero, matching the forward FFT.
//   - All adds/subtracts are DATA_W wrap-around. No saturation.
// - OUT: presents buffer[n], n=0..7. out_valid=1.
//   - n advances only on out_valid&out_ready.
//   - out_real/out_imag/out_last stay stable while out_valid=1 and out_ready=0.
//   - The accept of n=7 returns to LOAD. in_ready=1 on the next cycle.
// - Latency: 8th input accept at cycle T -> CALC in cycles T+1..T+12 -> out_valid=1 at T+13.
// - in_valid while not in LOAD is ignored. No bins are dropped or queued.
// - rst in any state aborts the frame: next cycle is LOAD, outputs at reset values, buffer contents don't-care.
// - out_ready=1 held constantly: frame period = 8 + 12 + 8 = 28 cycles.
// CONFIGURATION
// - IFFT_SCALE_EN defined: each output component is arithmetic-shifted right by 3 (1/N) when presented.
//   Round-trip FFT->IFFT returns the input, less truncation.
// - IFFT_SCALE_EN undefined: no scaling. Outputs equal N*x[n] in Q8.8, wrap-around on overflow.
// TESTING
// - Reset: rst=1 for 3 cycles -> out_valid=0, in_ready=0, busy=0. Cycle after release -> in_ready=1.
// - Impulse bins: X[0]=0x0100+j0, rest 0 -> all x[n]=0x0100+j0 (unscaled), 0x0020+j0 (IFFT_SCALE_EN).
//   out_last on the 8th sample only. First out_valid 13 cycles after the 8th accept.
// - Flat bins: all X[k]=0x0100+j0 -> x[0]=0x0800, others 0 (unscaled); x[0]=0x0100 (IFFT_SCALE_EN).
// - Single bin: X[1]=0x0100+j0 -> x[1]=0x00B4+j0x00B4, x[2]=0+j0x0100, x[3]=0xFF4C+j0x00B4 (unscaled).
// - Back-pressure: out_ready=0 for 5 cycles mid-OUT at n=3 -> x[3] held constant, no sample skipped.
//   in_ready=0 throughout.
// - Abort: rst pulse in CALC cycle 6 -> next cycle LOAD, out_valid=0. Fresh impulse frame then produces correct output.

Source files
------------

// File: rtl/ifft8_stream_if.sv
// rtl/ifft8_stream_if.sv - bin input / sample output stream bundle for the 8-point IFFT
interface ifft8_stream_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_real;
    logic [DATA_W-1:0] in_imag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_real;
    logic [DATA_W-1:0] out_imag;
    logic              out_last;

    modport master (
        output in_valid, in_real, in_imag, out_ready,
        input  in_ready, out_valid, out_real, out_imag, out_last
    );

    modport slave (
        input  in_valid, in_real, in_imag, out_ready,
        output in_ready, out_valid, out_real, out_imag, out_last
    );
endinterface

// File: rtl/ifft8_stream.sv
// rtl/ifft8_stream.sv - 8-point radix-2 DIT inverse FFT, Q8.8, one butterfly per clock (IFFT_SCALE_EN: 1/8 output scaling)
module ifft8_stream #(
    parameter int                DATA_W  = 16,
    parameter int                FRAC_W  = 8,
    parameter logic [DATA_W-1:0] TW_COEF = 16'h00B4
) (
    input  logic          clk,
    input  logic          rst,
    ifft8_stream_if.slave strm,
    output logic          busy
);
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t            state_q;
    logic [2:0]        ld_cnt_q;
    logic [3:0]        calc_cnt_q;
    logic [2:0]        out_cnt_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              busy_q;
    logic [DATA_W-1:0] out_re_q;
    logic [DATA_W-1:0] out_im_q;
    logic [DATA_W-1:0] mem_re_q [8];
    logic [DATA_W-1:0] mem_im_q [8];

    logic [2:0]        p_idx;
    logic [2:0]        q_idx;
    logic [1:0]        tw_k;
    logic [DATA_W-1:0] a_re, a_im, b_re, b_im;
    logic [DATA_W-1:0] b_sum, b_dif, b_nsum;
    logic [DATA_W-1:0] t_re, t_im;
    logic [DATA_W-1:0] bf_a_re_d, bf_a_im_d, bf_b_re_d, bf_b_im_d;

    // c*v with truncation toward zero: multiply the magnitude, then restore the sign
    function automatic logic [DATA_W-1:0] cmul(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0]   mag;
        logic [2*DATA_W-1:0] prod;
        logic [DATA_W-1:0]   res;
        mag  = v[DATA_W-1] ? (~v + 1'b1) : v;
        prod = (2*DATA_W)'(mag) * (2*DATA_W)'(TW_COEF);
        res  = DATA_W'(prod >> FRAC_W);
        return v[DATA_W-1] ? (~res + 1'b1) : res;
    endfunction

    // Output value as presented on the stream; optional 1/N scaling by arithmetic shift
    function automatic logic [DATA_W-1:0] present(input logic [DATA_W-1:0] v);
`ifdef IFFT_SCALE_EN
        return DATA_W'($signed(v) >>> 3);
`else
        return v;
`endif
    endfunction

    // Butterfly addressing and arithmetic for the current CALC step (stage = cnt[3:2], butterfly = cnt[1:0])
    always_comb begin
        p_idx = 3'd0;
        q_idx = 3'd0;
        tw_k  = 2'd0;
        case (calc_cnt_q[3:2])
            2'd0: begin
                p_idx = {calc_cnt_q[1:0], 1'b0};
                q_idx = {calc_cnt_q[1:0], 1'b1};
                tw_k  = 2'd0;
            end
            2'd1: begin
                p_idx = {calc_cnt_q[1], 1'b0, calc_cnt_q[0]};
                q_idx = {calc_cnt_q[1], 1'b1, calc_cnt_q[0]};
                tw_k  = {calc_cnt_q[0], 1'b0};
            end
            default: begin
                p_idx = {1'b0, calc_cnt_q[1:0]};
                q_idx = {1'b1, calc_cnt_q[1:0]};
                tw_k  = calc_cnt_q[1:0];
            end
        endcase

        a_re   = mem_re_q[p_idx];
        a_im   = mem_im_q[p_idx];
        b_re   = mem_re_q[q_idx];
        b_im   = mem_im_q[q_idx];
        b_sum  = b_re + b_im;
        b_dif  = b_re - b_im;
        b_nsum = ~b_sum + 1'b1;

        t_re = b_re;
        t_im = b_im;
        case (tw_k)
            2'd0: begin
                t_re = b_re;
                t_im = b_im;
            end
            2'd1: begin
                t_re = cmul(b_dif);
                t_im = cmul(b_sum);
            end
            2'd2: begin
                t_re = ~b_im + 1'b1;
                t_im = b_re;
            end
            default: begin
                t_re = cmul(b_nsum);
                t_im = cmul(b_dif);
            end
        endcase

        bf_a_re_d = a_re + t_re;
        bf_a_im_d = a_im + t_im;
        bf_b_re_d = a_re - t_re;
        bf_b_im_d = a_im - t_im;
    end

    // Frame sequencer: load bins bit-reversed, run 12 butterflies in place, stream samples out
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            ld_cnt_q    <= 3'd0;
            calc_cnt_q  <= 4'd0;
            out_cnt_q   <= 3'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    in_ready_q <= 1'b1;
                    if (strm.in_valid && in_ready_q) begin
                        mem_re_q[{ld_cnt_q[0], ld_cnt_q[1], ld_cnt_q[2]}] <= strm.in_real;
                        mem_im_q[{ld_cnt_q[0], ld_cnt_q[1], ld_cnt_q[2]}] <= strm.in_imag;
                        ld_cnt_q <= ld_cnt_q + 3'd1;
                        if (ld_cnt_q == 3'd7) begin
                            state_q    <= ST_CALC;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            calc_cnt_q <= 4'd0;
                        end
                    end
                end
                ST_CALC: begin
                    mem_re_q[p_idx] <= bf_a_re_d;
                    mem_im_q[p_idx] <= bf_a_im_d;
                    mem_re_q[q_idx] <= bf_b_re_d;
                    mem_im_q[q_idx] <= bf_b_im_d;
                    calc_cnt_q      <= calc_cnt_q + 4'd1;
                    if (calc_cnt_q == 4'd11) begin
                        // last butterfly touches entries 3 and 7, so entry 0 is already final
                        state_q     <= ST_OUT;
                        out_cnt_q   <= 3'd0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        out_re_q    <= present(mem_re_q[0]);
                        out_im_q    <= present(mem_im_q[0]);
                    end
                end
                ST_OUT: begin
                    if (out_valid_q && strm.out_ready) begin
                        if (out_cnt_q == 3'd7) begin
                            state_q     <= ST_LOAD;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_re_q    <= '0;
                            out_im_q    <= '0;
                            busy_q      <= 1'b0;
                            in_ready_q  <= 1'b1;
                            ld_cnt_q    <= 3'd0;
                        end else begin
                            out_cnt_q  <= out_cnt_q + 3'd1;
                            out_re_q   <= present(mem_re_q[out_cnt_q + 3'd1]);
                            out_im_q   <= present(mem_im_q[out_cnt_q + 3'd1]);
                            out_last_q <= (out_cnt_q == 3'd6);
                        end
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign strm.in_ready  = in_ready_q;
    assign strm.out_valid = out_valid_q;
    assign strm.out_real  = out_re_q;
    assign strm.out_imag  = out_im_q;
    assign strm.out_last  = out_last_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_ifft8_stream.sv
// tb/tb_ifft8_stream.sv - self-checking bench for ifft8_stream
module tb_ifft8_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    ifft8_stream_if #(.DATA_W(16)) bus ();

    ifft8_stream #(.DATA_W(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .strm (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int w16(input int v);
        int r;
        r = v & 32'h0000FFFF;
        if (r >= 32768) r = r - 65536;
        return r;
    endfunction

    function automatic int cm(input int v);
        if (v < 0) return w16(-(((-v) * 180) >>> 8));
        return w16((v * 180) >>> 8);
    endfunction

    function automatic int rev3(input int n);
        return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
    endfunction

    task automatic ifft_model(input int xr[8], input int xi[8], output int yr[8], output int yi[8]);
        int ar[8];
        int ai[8];
        int p, q, k, tr, ti, sr, si;
        for (int n = 0; n < 8; n++) begin
            ar[rev3(n)] = w16(xr[n]);
            ai[rev3(n)] = w16(xi[n]);
        end
        for (int span = 1; span < 8; span = span * 2) begin
            for (int start = 0; start < 8; start = start + 2 * span) begin
                for (int j = 0; j < span; j++) begin
                    p = start + j;
                    q = p + span;
                    k = j * (4 / span);
                    if (k == 0) begin
                        tr = ar[q];
                        ti = ai[q];
                    end else if (k == 2) begin
                        tr = w16(-ai[q]);
                        ti = ar[q];
                    end else begin
                        // rotation by c*(sr + j*si): k=1 -> (1,1), k=3 -> (-1,1)
                        sr = (k == 1) ? 1 : -1;
                        si = 1;
                        tr = cm(w16(sr * ar[q] - si * ai[q]));
                        ti = cm(w16(si * ar[q] + sr * ai[q]));
                    end
                    {ar[q], ai[q]} = {w16(ar[p] - tr), w16(ai[p] - ti)};
                    {ar[p], ai[p]} = {w16(ar[p] + tr), w16(ai[p] + ti)};
                end
            end
        end
        for (int n = 0; n < 8; n++) begin
`ifdef IFFT_SCALE_EN
            yr[n] = ar[n] >>> 3;
            yi[n] = ai[n] >>> 3;
`else
            yr[n] = ar[n];
            yi[n] = ai[n];
`endif
        end
    endtask

    // ---------------- scoreboard / compare ----------------
    int   exp_re_q[$];
    int   exp_im_q[$];
    int   exp_idx    = 0;
    int   accept_cyc = 0;
    bit   lat_armed  = 1'b0;
    bit   prev_valid = 1'b0;
    int   hold_cnt   = 0;

    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (lat_armed && !prev_valid) begin
                check("latency", cyc - accept_cyc, 13);
                lat_armed = 1'b0;
            end
            if (exp_re_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got out_valid=1 expected no sample pending");
            end else begin
                check($sformatf("out_real[%0d]", exp_idx), int'($signed(bus.out_real)), exp_re_q[0]);
                check($sformatf("out_imag[%0d]", exp_idx), int'($signed(bus.out_imag)), exp_im_q[0]);
                check($sformatf("out_last[%0d]", exp_idx), int'(bus.out_last), (exp_idx == 7) ? 1 : 0);
                check("in_ready_in_out", int'(bus.in_ready), 0);
                check("busy_in_out", int'(busy), 1);
                if (bus.out_ready) begin
                    void'(exp_re_q.pop_front());
                    void'(exp_im_q.pop_front());
                    exp_idx = (exp_idx + 1) % 8;
                end else begin
                    hold_cnt++;
                end
            end
        end
        prev_valid = bus.out_valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_frame(input int xr[8], input int xi[8], input int gap);
        int yr[8];
        int yi[8];
        int waited;
        ifft_model(xr, xi, yr, yi);
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_real  = 16'(xr[k]);
            bus.in_imag  = 16'(xi[k]);
            waited = 0;
            forever begin
                @(negedge clk);
                if (bus.in_ready) break;
                waited++;
                if (waited > 200) begin
                    $display("FAIL in_ready_timeout: got in_ready=0 for 200 cycles expected 1");
                    $fatal(1, "in_ready never asserted");
                end
            end
            if (k == 7) begin
                accept_cyc = cyc;
                lat_armed  = 1'b1;
                for (int n = 0; n < 8; n++) begin
                    exp_re_q.push_back(yr[n]);
                    exp_im_q.push_back(yi[n]);
                end
            end
            @(posedge clk);
            #1;
            if (gap > 0) begin
                bus.in_valid = 1'b0;
                repeat (gap) tick();
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_re_q.size() > 0 && w < 300) begin
            tick();
            w++;
        end
        check("drain_pending", exp_re_q.size(), 0);
        exp_re_q.delete();
        exp_im_q.delete();
        exp_idx = 0;
        tick();
        check("in_ready_after_frame", int'(bus.in_ready), 1);
        check("busy_after_frame", int'(busy), 0);
    endtask

    // ---------------- main sequence ----------------
    int xr[8];
    int xi[8];
    int yr[8];
    int yi[8];

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_real   = '0;
        bus.in_imag   = '0;
        bus.out_ready = 1'b1;

        // model pins: hand-computed values
        xr = '{256, 0, 0, 0, 0, 0, 0, 0};
        xi = '{0, 0, 0, 0, 0, 0, 0, 0};
        ifft_model(xr, xi, yr, yi);
`ifdef IFFT_SCALE_EN
        check("pin_impulse_x0", yr[0], 32);
        check("pin_impulse_x5", yr[5], 32);
`else
        check("pin_impulse_x0", yr[0], 256);
        check("pin_impulse_x5", yr[5], 256);
`endif
        check("pin_impulse_x5_im", yi[5], 0);
        xr = '{256, 256, 256, 256, 256, 256, 256, 256};
        ifft_model(xr, xi, yr, yi);
`ifdef IFFT_SCALE_EN
        check("pin_flat_x0", yr[0], 256);
`else
        check("pin_flat_x0", yr[0], 2048);
`endif
        check("pin_flat_x3", yr[3], 0);
        xr = '{0, 256, 0, 0, 0, 0, 0, 0};
        ifft_model(xr, xi, yr, yi);
`ifdef IFFT_SCALE_EN
        check("pin_single_x1_re", yr[1], 22);
        check("pin_single_x2_im", yi[2], 32);
        check("pin_single_x3_re", yr[3], -23);
`else
        check("pin_single_x1_re", yr[1], 180);
        check("pin_single_x1_im", yi[1], 180);
        check("pin_single_x2_re", yr[2], 0);
        check("pin_single_x2_im", yi[2], 256);
        check("pin_single_x3_re", yr[3], -180);
        check("pin_single_x3_im", yi[3], 180);
`endif

        // reset: three cycles with rst high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_out_valid", int'(bus.out_valid), 0);
            check("rst_in_ready", int'(bus.in_ready), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_out_real", int'(bus.out_real), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("in_ready_after_reset", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        // impulse
        xr = '{256, 0, 0, 0, 0, 0, 0, 0};
        xi = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(xr, xi, 0);
        drain();

        // flat
        xr = '{256, 256, 256, 256, 256, 256, 256, 256};
        send_frame(xr, xi, 0);
        drain();

        // single bin X[1]
        xr = '{0, 256, 0, 0, 0, 0, 0, 0};
        send_frame(xr, xi, 0);
        drain();

        // arbitrary complex bins, gapped input, junk in_valid during CALC
        xr = '{4660, -1280, 777, 32000, -32768, 100, -5, 12345};
        xi = '{-1280, 300, -29000, 4096, 7, -32000, 31000, -1};
        send_frame(xr, xi, 1);
        bus.in_valid = 1'b1;
        bus.in_real  = 16'h7FFF;
        bus.in_imag  = 16'h8000;
        repeat (10) tick();
        bus.in_valid = 1'b0;
        drain();

        // back-pressure at n=3
        xr = '{-300, 25000, -25000, 1000, 2000, -3000, 4000, 181};
        xi = '{50, -60, 70, -80, 90, 30000, -30000, 255};
        send_frame(xr, xi, 0);
        begin
            int w;
            w = 0;
            while (!(bus.out_valid && exp_idx == 3) && w < 100) begin
                tick();
                w++;
            end
            check("bp_reached_n3", (w < 100) ? 1 : 0, 1);
        end
        hold_cnt = 0;
        bus.out_ready = 1'b0;
        repeat (5) tick();
        bus.out_ready = 1'b1;
        check("bp_hold_cycles", hold_cnt, 5);
        drain();

        // abort during CALC cycle 6
        xr = '{256, 0, 0, 0, 0, 0, 0, 0};
        xi = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(xr, xi, 0);
        repeat (5) tick();
        exp_re_q.delete();
        exp_im_q.delete();
        lat_armed = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_valid", int'(bus.out_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(bus.in_ready), 0);
        tick();
        check("abort_in_ready_next", int'(bus.in_ready), 1);
        send_frame(xr, xi, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
